// File: rtl/ysyx_22050550_pcgen_btb.sv
// ysyx_22050550_pcgen_btb
// Fetch-PC generator with a direct-mapped branch target buffer and 2-bit
// saturating direction counters. The next PC is chosen in this order:
// trap, then resolve-stage redirect, then prediction (when ready), else hold.
// The BTB and prediction exist only when YSYX_22050550_BTB_EN is defined.
// Without it, fetch falls through to pc+4 and the upd_* inputs are ignored.
module ysyx_22050550_pcgen_btb #(
    parameter int unsigned       XLEN      = 64,
    parameter logic [XLEN-1:0]   RESET_PC  = XLEN'(64'h8000_0000),
    parameter int unsigned       BTB_DEPTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ready,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [1:0]      upd_kind,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // Pick the PC for the next edge; reset forces RESET_PC combinationally
    always_comb begin
        if (!reset) begin
            next_pc = RESET_PC;
        end else if (trap_valid) begin
            next_pc = trap_pc;
        end else if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (ready) begin
            next_pc = pred_target;
        end else begin
            next_pc = pc;
        end
    end

    // Fetch PC register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

`ifdef YSYX_22050550_BTB_EN
    localparam int unsigned IDXW = $clog2(BTB_DEPTH);
    localparam int unsigned TAGW = XLEN - IDXW - 2;

    typedef enum logic [1:0] {
        KIND_BR   = 2'd0,
        KIND_JAL  = 2'd1,
        KIND_JALR = 2'd2,
        KIND_RSVD = 2'd3
    } upd_kind_e;

    logic [BTB_DEPTH-1:0] btb_valid;
    logic [BTB_DEPTH-1:0] btb_uncond;
    logic [TAGW-1:0]      btb_tag    [BTB_DEPTH];
    logic [XLEN-1:0]      btb_target [BTB_DEPTH];
    logic [1:0]           btb_ctr    [BTB_DEPTH];

    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic [IDXW-1:0] up_idx;
    logic [TAGW-1:0] up_tag;
    logic            up_hit;
    logic            unused_upd_lsb;

    assign lk_idx = pc[IDXW+1:2];
    assign lk_tag = pc[XLEN-1:IDXW+2];
    assign lk_hit = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);

    assign up_idx = upd_pc[IDXW+1:2];
    assign up_tag = upd_pc[XLEN-1:IDXW+2];
    assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);

    // Instruction alignment bits never select an entry
    assign unused_upd_lsb = ^upd_pc[1:0];

    // Lookup reads the array before this cycle's update is written
    always_comb begin
        pred_taken  = lk_hit && (btb_uncond[lk_idx] || btb_ctr[lk_idx][1]);
        pred_target = pred_taken ? btb_target[lk_idx] : pc + PC_STEP;
    end

    // Train the BTB from resolved control flow; reset drops any pending update
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btb_valid  <= '0;
            btb_uncond <= '0;
            btb_tag    <= '{default: '0};
            btb_target <= '{default: '0};
            btb_ctr    <= '{default: '0};
        end else if (upd_valid) begin
            case (upd_kind_e'(upd_kind))
                KIND_JAL: begin
                    btb_valid[up_idx]  <= 1'b1;
                    btb_uncond[up_idx] <= 1'b1;
                    btb_tag[up_idx]    <= up_tag;
                    btb_target[up_idx] <= upd_target;
                    btb_ctr[up_idx]    <= 2'b11;
                end
                KIND_BR: begin
                    if (upd_taken && up_hit) begin
                        btb_target[up_idx] <= upd_target;
                        if (btb_ctr[up_idx] != 2'b11) begin
                            btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
                        end
                    end else if (upd_taken) begin
                        btb_valid[up_idx]  <= 1'b1;
                        btb_uncond[up_idx] <= 1'b0;
                        btb_tag[up_idx]    <= up_tag;
                        btb_target[up_idx] <= upd_target;
                        btb_ctr[up_idx]    <= 2'b10;
                    end else if (up_hit && (btb_ctr[up_idx] != 2'b00)) begin
                        btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
`else
    logic unused_upd;

    assign unused_upd = ^{upd_valid, upd_pc, upd_kind, upd_taken, upd_target};

    // No predictor: always fall through to the sequential PC
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc + PC_STEP;
    end
`endif

endmodule

// File: tb/tb_ysyx_22050550_pcgen_btb.sv
// tb_ysyx_22050550_pcgen_btb
// Randomized plus directed stimulus against a behavioural model of the fetch
// PC generator. Expected outputs are queued per cycle and checked by a
// separate monitor. The model follows YSYX_22050550_BTB_EN like the design.
module tb_ysyx_22050550_pcgen_btb;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 8;
    localparam logic [63:0] BASE  = 64'h8000_0000;
`ifdef YSYX_22050550_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic            clock;
    logic            reset;
    logic            ready;
    logic            trap_valid;
    logic [XLEN-1:0] trap_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic [1:0]      upd_kind;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    ysyx_22050550_pcgen_btb #(
        .XLEN      (XLEN),
        .RESET_PC  (BASE),
        .BTB_DEPTH (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ready          (ready),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_kind       (upd_kind),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .pc             (pc),
        .next_pc        (next_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] target;
        logic [63:0] nxt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: each entry remembers the full word address it holds
    logic [63:0] m_pc;
    bit          m_valid  [DEPTH];
    bit          m_uncond [DEPTH];
    logic [63:0] m_line   [DEPTH];
    logic [63:0] m_tgt    [DEPTH];
    int          m_ctr    [DEPTH];

    function automatic int unsigned slot_of(input logic [63:0] a);
        return 32'((a >> 2) % 64'(DEPTH));
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i]  = 1'b0;
            m_uncond[i] = 1'b0;
            m_line[i]   = '0;
            m_tgt[i]    = '0;
            m_ctr[i]    = 0;
        end
    endfunction

    function automatic void m_lookup(input logic [63:0] a, output bit t, output logic [63:0] tg);
        int unsigned s = slot_of(a);
        t = 1'b0;
        if (BTB_ON && m_valid[s] && m_line[s] == (a >> 2))
            t = m_uncond[s] || (m_ctr[s] >= 2);
        tg = t ? m_tgt[s] : a + 64'd4;
    endfunction

    function automatic void m_update(input logic [63:0] a, input logic [1:0] k,
                                     input bit tk, input logic [63:0] tg);
        int unsigned s = slot_of(a);
        bit hit = m_valid[s] && m_line[s] == (a >> 2);
        if (!BTB_ON) return;
        if (k == 2'd1) begin
            m_valid[s] = 1'b1; m_uncond[s] = 1'b1; m_line[s] = a >> 2;
            m_tgt[s] = tg; m_ctr[s] = 3;
        end else if (k == 2'd0) begin
            if (tk && hit) begin
                m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                m_tgt[s] = tg;
            end else if (tk) begin
                m_valid[s] = 1'b1; m_uncond[s] = 1'b0; m_line[s] = a >> 2;
                m_tgt[s] = tg; m_ctr[s] = 2;
            end else if (hit) begin
                m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
            end
        end
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle of inputs, queue the expected response, advance the model
    task automatic cycle(input bit rst, input bit rdy,
                         input bit tv, input logic [63:0] tp,
                         input bit rv, input logic [63:0] rp,
                         input bit uv, input logic [63:0] up, input logic [1:0] uk,
                         input bit ut, input logic [63:0] utg);
        exp_t        e;
        bit          pt;
        logic [63:0] ptg;
        logic [63:0] nx;
        @(negedge clock);
        reset = ~rst; ready = rdy;
        trap_valid = tv; trap_pc = tp;
        redirect_valid = rv; redirect_pc = rp;
        upd_valid = uv; upd_pc = up; upd_kind = uk; upd_taken = ut; upd_target = utg;
        if (rst) begin
            m_pc = BASE;
            m_clear();
        end
        m_lookup(m_pc, pt, ptg);
        if (rst)       nx = BASE;
        else if (tv)   nx = tp;
        else if (rv)   nx = rp;
        else if (rdy)  nx = ptg;
        else           nx = m_pc;
        e.pc = m_pc; e.taken = pt; e.target = ptg; e.nxt = nx;
        sb.push_back(e);
        if (!rst) begin
            if (uv) m_update(up, uk, ut, utg);
            m_pc = nx;
        end
    endtask

    task automatic step(input bit rdy);
        cycle(1'b0, rdy, 1'b0, '0, 1'b0, '0, 1'b0, '0, 2'd0, 1'b0, '0);
    endtask

    task automatic upd(input bit rdy, input logic [63:0] a, input logic [1:0] k,
                       input bit tk, input logic [63:0] tg);
        cycle(1'b0, rdy, 1'b0, '0, 1'b0, '0, 1'b1, a, k, tk, tg);
    endtask

    task automatic redir(input logic [63:0] a);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, a, 1'b0, '0, 2'd0, 1'b0, '0);
    endtask

    function automatic logic [63:0] rnd_pc();
        return BASE + 64'(4 * $urandom_range(0, 63));
    endfunction

    // Monitor: compare queued expectations mid-cycle, away from both edges
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc", pc, e.pc);
                chk("pred_taken", 64'(pred_taken), 64'(e.taken));
                chk("pred_target", pred_target, e.target);
                chk("next_pc", next_pc, e.nxt);
            end
        end
    end

    initial begin
        reset = 1'b0; ready = 1'b0;
        trap_valid = 1'b0; trap_pc = '0;
        redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_kind = '0; upd_taken = 1'b0; upd_target = '0;
        m_pc = BASE;
        m_clear();

        // Reset, then sequential fetch
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, BASE, 2'd1, 1'b1, BASE + 64'h40);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 2'd0, 1'b0, '0);
        step(1'b1); step(1'b1); step(1'b1);
        // jal at 8000_0010 learned while fetching 8000_000C, then predicted
        upd(1'b1, BASE + 64'h10, 2'd1, 1'b1, BASE + 64'h100);
        step(1'b1); step(1'b1); step(1'b0);
        // Conditional branch: taken once, then not taken twice
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, BASE + 64'h20, 1'b1, BASE + 64'h20, 2'd0, 1'b1, BASE + 64'h40);
        upd(1'b0, BASE + 64'h20, 2'd0, 1'b0, BASE + 64'h40);
        upd(1'b0, BASE + 64'h20, 2'd0, 1'b0, BASE + 64'h40);
        step(1'b1); step(1'b0);
        // Trap beats redirect, regardless of ready
        cycle(1'b0, 1'b0, 1'b1, BASE + 64'h1000, 1'b1, BASE + 64'h2000, 1'b0, '0, 2'd0, 1'b0, '0);
        step(1'b0);
        // Alias on the jal's index with a different tag
        redir(BASE + 64'h30);
        step(1'b1); step(1'b1);
        // jalr and reserved kinds never allocate
        upd(1'b0, BASE + 64'h50, 2'd2, 1'b1, BASE + 64'h200);
        upd(1'b0, BASE + 64'h50, 2'd3, 1'b1, BASE + 64'h200);
        redir(BASE + 64'h50);
        step(1'b1);
        // Reset mid-run with a pending update; earlier entries are gone
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, BASE + 64'h60, 2'd1, 1'b1, BASE + 64'h300);
        step(1'b0);
        redir(BASE + 64'h10);
        step(1'b1); step(1'b1);

        // Randomized traffic confined to a small window so entries get reused
        for (int n = 0; n < 3000; n++) begin
            bit          rst = ($urandom_range(0, 199) == 0);
            bit          tv  = ($urandom_range(0, 19) == 0);
            bit          rv  = ($urandom_range(0, 11) == 0);
            bit          uv  = ($urandom_range(0, 1) == 1);
            logic [63:0] rp  = rnd_pc() + 64'($urandom_range(0, 3));
            cycle(rst, ($urandom_range(0, 3) != 0),
                  tv, rnd_pc(), rv, rp,
                  uv, rnd_pc(), 2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0), rnd_pc());
        end
        step(1'b0);

        // Let the monitor drain, with a bounded wait
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clock);
        #4;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
